unstripe_sequencer: RTL and testbench

- Controller that sequences byte unstriping for the PCIe lane path.
- Accepts a serial byte stream with a valid/ready handshake and tracks the byte position within the current word. Packs bytes MSB-first into 8/16/32-bit words and presents each word on a one-entry output register with valid/ready.
- Owns the width configuration: new modes are applied only at word boundaries, so a mode change can never split a word.

---
 rtl/unstripe_pkg.sv | 40 ++++
 rtl/unstripe_outreg.sv | 35 +++
 rtl/unstripe_sequencer.sv | 156 +++++++++++++++
 tb/tb_unstripe_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/unstripe_pkg.sv
// Shared definitions for the byte unstriping path: width codes, the
// sequencer state encoding and small mode helper functions.
package unstripe_pkg;

  // Width codes as seen on cfg_mode / out_mode / active_mode.
  localparam logic [1:0] MODE_8     = 2'b00;
  localparam logic [1:0] MODE_16    = 2'b01;
  localparam logic [1:0] MODE_32    = 2'b10;
  localparam logic [1:0] MODE_8_ALT = 2'b11;

  // Sequencer state: IDLE sits on a word boundary, FILL holds a partial word.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // Fold the alternate 8-bit code onto the canonical one so that 2'b11
  // never propagates into active_mode or out_mode.
  function automatic logic [1:0] normalise(input logic [1:0] mode);
    logic [1:0] res;
    if (mode == MODE_8_ALT) begin
      res = MODE_8;
    end else begin
      res = mode;
    end
    return res;
  endfunction

  // Number of bytes that make up one word in the given mode.
  function automatic logic [2:0] bytes_per_word(input logic [1:0] mode);
    logic [2:0] res;
    case (normalise(mode))
      MODE_16: res = 3'd2;
      MODE_32: res = 3'd4;
      default: res = 3'd1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/unstripe_outreg.sv
// One-entry valid/ready output register. A load always wins over a drain,
// so a word completing in the same cycle the previous one is taken keeps
// out_valid high with the new contents.
module unstripe_outreg
  import unstripe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [1:0]  load_mode,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_mode,
  output logic        out_valid
);

  // Hold the word until the consumer takes it; replace it on a new load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= 32'h0000_0000;
      out_mode  <= MODE_8;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_mode  <= load_mode;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: rtl/unstripe_sequencer.sv
// Byte unstriping sequencer: accepts a byte stream, tracks the byte
// position inside the current word, packs bytes MSB-first into 8/16/32-bit
// words and hands each finished word to a one-entry output register.
// Width changes take effect only on word boundaries.
module unstripe_sequencer
  import unstripe_pkg::*;
#(
  parameter int FLUSH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enb,
  input  logic [1:0]             cfg_mode,
  input  logic                   flush,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [31:0]            out_data,
  output logic [1:0]             out_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             byte_idx,
  output logic [1:0]             active_mode,
  output logic                   mode_pending,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE = {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_MAX = {FLUSH_CNT_W{1'b1}};

  state_t                 state_r;
  state_t                 state_n;
  logic [1:0]             byte_idx_r;
  logic [1:0]             byte_idx_n;
  logic [23:0]            partial_r;
  logic [23:0]            partial_n;
  logic [1:0]             active_mode_r;
  logic [1:0]             active_mode_n;
  logic [FLUSH_CNT_W-1:0] flush_cnt_r;
  logic [FLUSH_CNT_W-1:0] flush_cnt_n;

  logic [1:0]             cfg_norm_s;
  logic [1:0]             word_mode_s;
  logic [2:0]             word_bytes_s;
  logic                   accept_s;
  logic                   last_byte_s;
  logic                   load_s;
  logic [31:0]            load_data_s;

  // While on a word boundary the requested mode is the one the next byte
  // will use (it is latched in the same cycle); mid-word the latched mode
  // stays in force.
  always_comb begin
    cfg_norm_s   = normalise(cfg_mode);
    if (state_r == ST_IDLE) begin
      word_mode_s = cfg_norm_s;
    end else begin
      word_mode_s = active_mode_r;
    end
    word_bytes_s = bytes_per_word(word_mode_s);
    last_byte_s  = ({1'b0, byte_idx_r} == (word_bytes_s - 3'd1));
    // The partial word is kept right-justified and zero above the bytes
    // received so far, so appending the new byte yields the packed word.
    load_data_s  = {partial_r, in_data};
  end

  // Handshake and status flags; in_ready is forced low while in reset.
  always_comb begin
    in_ready     = !reset && enb && !flush && (!out_valid || out_ready);
    accept_s     = in_valid && in_ready;
    mode_pending = (cfg_norm_s != active_mode_r) && (state_r == ST_FILL);
  end

  // Next-state logic: mode latching, byte counting, packing and flush.
  always_comb begin
    state_n       = state_r;
    byte_idx_n    = byte_idx_r;
    partial_n     = partial_r;
    active_mode_n = active_mode_r;
    flush_cnt_n   = flush_cnt_r;
    load_s        = 1'b0;
    if (enb) begin
      if (state_r == ST_IDLE) begin
        active_mode_n = cfg_norm_s;
      end else begin
        active_mode_n = active_mode_r;
      end
      if (flush) begin
        if (state_r == ST_FILL) begin
          state_n    = ST_IDLE;
          byte_idx_n = 2'd0;
          partial_n  = 24'h00_0000;
          if (flush_cnt_r == FLUSH_MAX) begin
            flush_cnt_n = flush_cnt_r;
          end else begin
            flush_cnt_n = flush_cnt_r + FLUSH_ONE;
          end
        end else begin
          state_n = state_r;
        end
      end else if (accept_s) begin
        if (last_byte_s) begin
          load_s     = 1'b1;
          state_n    = ST_IDLE;
          byte_idx_n = 2'd0;
          partial_n  = 24'h00_0000;
        end else begin
          state_n    = ST_FILL;
          byte_idx_n = byte_idx_r + 2'd1;
          partial_n  = load_data_s[23:0];
        end
      end else begin
        state_n = state_r;
      end
    end else begin
      state_n = state_r;
    end
  end

  // State register; a reset mid-word drops the partial word silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      byte_idx_r    <= 2'd0;
      partial_r     <= 24'h00_0000;
      active_mode_r <= MODE_8;
      flush_cnt_r   <= {FLUSH_CNT_W{1'b0}};
    end else begin
      state_r       <= state_n;
      byte_idx_r    <= byte_idx_n;
      partial_r     <= partial_n;
      active_mode_r <= active_mode_n;
      flush_cnt_r   <= flush_cnt_n;
    end
  end

  unstripe_outreg u_outreg (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .load_data (load_data_s),
    .load_mode (word_mode_s),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_valid (out_valid)
  );

  // Status outputs come straight from registers.
  always_comb begin
    byte_idx    = byte_idx_r;
    active_mode = active_mode_r;
    flush_cnt   = flush_cnt_r;
  end

endmodule

// File: tb/tb_unstripe_sequencer.sv
// Directed, table-driven bench for unstripe_sequencer. Inputs change 1 time
// unit after the rising edge, outputs are sampled on the falling edge.
module tb_unstripe_sequencer;

  logic        clk;
  logic        reset;
  logic        enb;
  logic [1:0]  cfg_mode;
  logic        flush;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  byte_idx;
  logic [1:0]  active_mode;
  logic        mode_pending;
  logic [7:0]  flush_cnt;

  int total  = 0;
  int passed = 0;

  unstripe_sequencer #(.FLUSH_CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .enb          (enb),
    .cfg_mode     (cfg_mode),
    .flush        (flush),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_mode     (out_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .byte_idx     (byte_idx),
    .active_mode  (active_mode),
    .mode_pending (mode_pending),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        enb;
    logic [1:0]  cfg;
    logic        flush;
    logic        vin;
    logic [7:0]  din;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [1:0]  e_mode;
    logic [1:0]  e_idx;
    logic [1:0]  e_act;
    logic        e_pend;
    logic [7:0]  e_fcnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic [1:0] c, input logic f, input logic v,
                     input logic [7:0] d, input logic r, input logic x_rdy, input logic x_ov,
                     input logic [31:0] x_data, input logic [1:0] x_mode, input logic [1:0] x_idx,
                     input logic [1:0] x_act, input logic x_pend, input logic [7:0] x_fcnt);
    vec_t t;
    t.enb = e; t.cfg = c; t.flush = f; t.vin = v; t.din = d; t.ordy = r;
    t.e_rdy = x_rdy; t.e_ov = x_ov; t.e_data = x_data; t.e_mode = x_mode;
    t.e_idx = x_idx; t.e_act = x_act; t.e_pend = x_pend; t.e_fcnt = x_fcnt;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " in_ready"},     32'(in_ready),     32'd0);
    chk({tag, " out_data"},     out_data,          32'd0);
    chk({tag, " out_mode"},     32'(out_mode),     32'd0);
    chk({tag, " out_valid"},    32'(out_valid),    32'd0);
    chk({tag, " byte_idx"},     32'(byte_idx),     32'd0);
    chk({tag, " active_mode"},  32'(active_mode),  32'd0);
    chk({tag, " mode_pending"}, 32'(mode_pending), 32'd0);
    chk({tag, " flush_cnt"},    32'(flush_cnt),    32'd0);
  endtask

  task automatic drive(input logic e, input logic [1:0] c, input logic f, input logic v,
                       input logic [7:0] d, input logic r);
    enb = e; cfg_mode = c; flush = f; in_valid = v; in_data = d; out_ready = r;
  endtask

  initial begin
    int words;
    reset = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1);

    // enb cfg flush vin din ordy | rdy ov data mode idx act pend fcnt
    // 16-bit word AB CD, with an enb-low stall in the middle
    add(1'b1, 2'b01, 1'b0, 1'b1, 8'hAB, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd0, 2'b00, 1'b0, 8'd0);
    add(1'b0, 2'b01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 2'd1, 2'b01, 1'b0, 8'd0);
    add(1'b1, 2'b01, 1'b0, 1'b1, 8'hCD, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd1, 2'b01, 1'b0, 8'd0);
    add(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0000ABCD, 2'b01, 2'd0, 2'b01, 1'b0, 8'd0);
    add(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd0, 2'b01, 1'b0, 8'd0);
    // 32-bit with backpressure
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 2'd0, 2'b01, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 2'd1, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 2'd2, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 2'd3, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h11223344, 2'b10, 2'd0, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h11223344, 2'b10, 2'd0, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 32'h11223344, 2'b10, 2'd0, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd1, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd2, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h88, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd3, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 32'h55667788, 2'b10, 2'd0, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h55667788, 2'b10, 2'd0, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd0, 2'b10, 1'b0, 8'd0);
    // mode change requested mid-word
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd0, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd1, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b01, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd2, 2'b10, 1'b1, 8'd0);
    add(1'b1, 2'b01, 1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd3, 2'b10, 1'b1, 8'd0);
    add(1'b1, 2'b01, 1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 32'h01020304, 2'b10, 2'd0, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b01, 1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd1, 2'b01, 1'b0, 8'd0);
    add(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h00000506, 2'b01, 2'd0, 2'b01, 1'b0, 8'd0);
    // flush in FILL, clean word, flush in IDLE while a word drains
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd0, 2'b01, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h0B, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd1, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'h0C, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd2, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b1, 1'b1, 8'hDD, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 2'd3, 2'b10, 1'b0, 8'd0);
    add(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd0, 2'b10, 1'b0, 8'd1);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'hC1, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd0, 2'b10, 1'b0, 8'd1);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'hC2, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd1, 2'b10, 1'b0, 8'd1);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd2, 2'b10, 1'b0, 8'd1);
    add(1'b1, 2'b10, 1'b0, 1'b1, 8'hC4, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd3, 2'b10, 1'b0, 8'd1);
    add(1'b1, 2'b10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'hC1C2C3C4, 2'b10, 2'd0, 2'b10, 1'b0, 8'd1);
    add(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, 2'd0, 2'b10, 1'b0, 8'd1);

    // power-on reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].enb, vecs[i].cfg, vecs[i].flush, vecs[i].vin, vecs[i].din, vecs[i].ordy);
      @(negedge clk);
      chk($sformatf("row%0d in_ready", i),     32'(in_ready),     32'(vecs[i].e_rdy));
      chk($sformatf("row%0d out_valid", i),    32'(out_valid),    32'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("row%0d out_data", i), out_data,          vecs[i].e_data);
        chk($sformatf("row%0d out_mode", i), 32'(out_mode),     32'(vecs[i].e_mode));
      end
      chk($sformatf("row%0d byte_idx", i),     32'(byte_idx),     32'(vecs[i].e_idx));
      chk($sformatf("row%0d active_mode", i),  32'(active_mode),  32'(vecs[i].e_act));
      chk($sformatf("row%0d mode_pending", i), 32'(mode_pending), 32'(vecs[i].e_pend));
      chk($sformatf("row%0d flush_cnt", i),    32'(flush_cnt),    32'(vecs[i].e_fcnt));
      @(posedge clk);
      #1;
    end

    // 8-bit via the alternate code: one word per cycle, no bubbles
    words = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b11, 1'b0, 1'b1, 8'(i), 1'b1);
      @(negedge clk);
      chk($sformatf("b8 in_ready %0d", i), 32'(in_ready), 32'd1);
      chk($sformatf("b8 byte_idx %0d", i), 32'(byte_idx), 32'd0);
      if (out_valid) words++;
      if (i > 0) begin
        chk($sformatf("b8 out_valid %0d", i),   32'(out_valid),   32'd1);
        chk($sformatf("b8 out_data %0d", i),    out_data,         32'(i - 1));
        chk($sformatf("b8 out_mode %0d", i),    32'(out_mode),    32'd0);
        chk($sformatf("b8 active_mode %0d", i), 32'(active_mode), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    if (out_valid) words++;
    chk("b8 last out_data", out_data, 32'h0000000F);
    chk("b8 word count", 32'(words), 32'd16);
    @(posedge clk);
    #1;

    // async reset while an output word is held
    drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h12, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h34, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    chk("pre-reset out_data", out_data, 32'h00001234);
    #2 reset = 1'b1;
    #1 check_reset("rst_ov");
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // async reset mid-word
    drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h77, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("pre-reset byte_idx", 32'(byte_idx), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset("rst_mid");
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // fresh 16-bit word after reset starts from byte 0
    drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h5A, 1'b1);
    @(negedge clk);
    chk("post byte_idx 0", 32'(byte_idx), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b1, 2'b01, 1'b0, 1'b1, 8'hA5, 1'b1);
    @(negedge clk);
    chk("post byte_idx 1", 32'(byte_idx), 32'd1);
    @(posedge clk);
    #1;
    drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("post out_valid", 32'(out_valid), 32'd1);
    chk("post out_data", out_data, 32'h00005AA5);
    chk("post out_mode", 32'(out_mode), 32'd1);
    chk("post byte_idx end", 32'(byte_idx), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
